lsu_mem_port: RTL and testbench

//  Load/store front-end that sits directly upstream of the data SRAM wrapper.

---
 rtl/lsu_pkg.sv | 44 ++++
 rtl/lsu_align.sv | 65 ++++++
 rtl/lsu_mem_port.sv | 196 +++++++++++++++++++
 tb/tb_lsu_mem_port.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared constants and types for the LSU memory port.
//   - Access size codes (byte/half/word/illegal)
//   - FSM state constants (IDLE, ISSUE, WAIT, RESP)
//   - Byte-mask base patterns, one per legal size
//   - Latched request record and the alignment/legality helper
package lsu_pkg;

  localparam logic [1:0] SIZE_B   = 2'b00;
  localparam logic [1:0] SIZE_H   = 2'b01;
  localparam logic [1:0] SIZE_W   = 2'b10;
  localparam logic [1:0] SIZE_ILL = 2'b11;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  localparam logic [3:0] MASK_B = 4'b0001;
  localparam logic [3:0] MASK_H = 4'b0011;
  localparam logic [3:0] MASK_W = 4'b1111;

  // Request fields kept for the life of one operation.
  typedef struct packed {
    logic        wen;
    logic [1:0]  size;
    logic        uns;
    logic [1:0]  off;
    logic [31:0] wdata;
  } lsu_req_t;

  // True when the access can never reach the SRAM: size=11 or a half/word
  // that is not naturally aligned.
  function automatic logic req_illegal(input logic [1:0] size, input logic [1:0] off);
    logic bad;
    case (size)
      SIZE_B:  bad = 1'b0;
      SIZE_H:  bad = off[0];
      SIZE_W:  bad = (off != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align: combinational byte-lane steering for the LSU.
// Ports:
//   size, off   access size code and byte offset within the word
//   uns         zero-extend loads when 1
//   wdata       right-justified store data
//   rdata       raw SRAM read word
//   wmask       byte mask (upper nibble always 0)
//   wdata_sh    store data moved into its byte lanes
//   load_ext    load data moved down and sign/zero-extended
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  off,
  input  logic        uns,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [7:0]  wmask,
  output logic [31:0] wdata_sh,
  output logic [31:0] load_ext
);

  logic [3:0]  base_s;
  logic [4:0]  shamt_s;
  logic [31:0] rd_sh_s;

  // Select the unshifted byte-mask pattern for the access size.
  always_comb begin
    base_s = 4'b0000;
    case (size)
      SIZE_B:  base_s = MASK_B;
      SIZE_H:  base_s = MASK_H;
      SIZE_W:  base_s = MASK_W;
      default: base_s = 4'b0000;
    endcase
  end

  assign shamt_s  = {off, 3'b000};
  assign wmask    = {4'b0000, base_s << off};
  assign wdata_sh = wdata << shamt_s;
  assign rd_sh_s  = rdata >> shamt_s;

  // Extend the addressed byte/half from bit 7/15 unless unsigned.
  always_comb begin
    load_ext = rd_sh_s;
    case (size)
      SIZE_B: begin
        if (uns) begin
          load_ext = {24'h000000, rd_sh_s[7:0]};
        end else begin
          load_ext = {{24{rd_sh_s[7]}}, rd_sh_s[7:0]};
        end
      end
      SIZE_H: begin
        if (uns) begin
          load_ext = {16'h0000, rd_sh_s[15:0]};
        end else begin
          load_ext = {{16{rd_sh_s[15]}}, rd_sh_s[15:0]};
        end
      end
      default: load_ext = rd_sh_s;
    endcase
  end

endmodule

// File: rtl/lsu_mem_port.sv
// lsu_mem_port: single-outstanding RV32 load/store front-end for the data SRAM.
// Ports:
//   clk, rst                    clock; asynchronous active-low reset
//   req_valid/req_ready         EXU request handshake (ready only when idle)
//   req_wen/size/uns/addr/wdata request fields
//   mem_en/wen/wmask/addr/wdata registered SRAM command (active in ISSUE only)
//   mem_rdata                   SRAM read data, one cycle after mem_en
//   resp_valid/resp_ready       response handshake, valid held until accepted
//   resp_rdata/resp_err         extended load data / illegal-access flag
module lsu_mem_port
  import lsu_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_wen,
  input  logic [1:0]            req_size,
  input  logic                  req_uns,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  mem_en,
  output logic                  mem_wen,
  output logic [7:0]            mem_wmask,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err
);

  logic [1:0]            state_r;
  logic [1:0]            state_nx_s;
  lsu_req_t              req_r;
  logic                  accept_s;
  logic                  illegal_s;
  logic                  req_ready_r;
  logic                  resp_valid_r;
  logic                  resp_err_r;
  logic [DATA_WIDTH-1:0] resp_rdata_r;
  logic                  mem_en_r;
  logic                  mem_wen_r;
  logic [7:0]            mem_wmask_r;
  logic [ADDR_WIDTH-1:0] mem_addr_r;
  logic [DATA_WIDTH-1:0] mem_wdata_r;

  logic [1:0]  al_size_s;
  logic [1:0]  al_off_s;
  logic [31:0] al_wdata_s;
  logic [7:0]  wmask_s;
  logic [31:0] wdata_sh_s;
  logic [31:0] load_ext_s;

  assign accept_s  = req_valid & req_ready_r;
  assign illegal_s = req_illegal(req_size, req_addr[1:0]);

  // While idle the aligner sees the incoming request (to build the SRAM
  // command); afterwards it sees the latched fields (to extend the load).
  always_comb begin
    al_size_s  = req_r.size;
    al_off_s   = req_r.off;
    al_wdata_s = req_r.wdata;
    if (state_r == ST_IDLE) begin
      al_size_s  = req_size;
      al_off_s   = req_addr[1:0];
      al_wdata_s = req_wdata;
    end else begin
      al_size_s  = req_r.size;
      al_off_s   = req_r.off;
      al_wdata_s = req_r.wdata;
    end
  end

  lsu_align u_align (
    .size     (al_size_s),
    .off      (al_off_s),
    .uns      (req_r.uns),
    .wdata    (al_wdata_s),
    .rdata    (mem_rdata),
    .wmask    (wmask_s),
    .wdata_sh (wdata_sh_s),
    .load_ext (load_ext_s)
  );

  // Next-state logic: illegal requests skip the SRAM and go straight to RESP.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          if (illegal_s) begin
            state_nx_s = ST_RESP;
          end else begin
            state_nx_s = ST_ISSUE;
          end
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (req_r.wen) begin
          state_nx_s = ST_RESP;
        end else begin
          state_nx_s = ST_WAIT;
        end
      end
      ST_WAIT: state_nx_s = ST_RESP;
      ST_RESP: begin
        if (resp_ready) begin
          state_nx_s = ST_IDLE;
        end else begin
          state_nx_s = ST_RESP;
        end
      end
      default: state_nx_s = ST_IDLE;
    endcase
  end

  // State, request latch and all registered outputs. Handshake outputs are
  // derived from the next state so they line up with the state they describe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r      <= ST_IDLE;
      req_r        <= {$bits(lsu_req_t){1'b0}};
      req_ready_r  <= 1'b1;
      resp_valid_r <= 1'b0;
      resp_err_r   <= 1'b0;
      resp_rdata_r <= {DATA_WIDTH{1'b0}};
      mem_en_r     <= 1'b0;
      mem_wen_r    <= 1'b0;
      mem_wmask_r  <= 8'h00;
      mem_addr_r   <= {ADDR_WIDTH{1'b0}};
      mem_wdata_r  <= {DATA_WIDTH{1'b0}};
    end else begin
      state_r      <= state_nx_s;
      req_ready_r  <= (state_nx_s == ST_IDLE);
      resp_valid_r <= (state_nx_s == ST_RESP);
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            req_r.wen    <= req_wen;
            req_r.size   <= req_size;
            req_r.uns    <= req_uns;
            req_r.off    <= req_addr[1:0];
            req_r.wdata  <= req_wdata;
            resp_rdata_r <= {DATA_WIDTH{1'b0}};
            resp_err_r   <= illegal_s;
            if (!illegal_s) begin
              mem_en_r    <= 1'b1;
              mem_wen_r   <= req_wen;
              mem_wmask_r <= wmask_s;
              mem_addr_r  <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
              mem_wdata_r <= wdata_sh_s;
            end
          end
        end
        ST_ISSUE: begin
          mem_en_r    <= 1'b0;
          mem_wen_r   <= 1'b0;
          mem_wmask_r <= 8'h00;
          mem_addr_r  <= {ADDR_WIDTH{1'b0}};
          mem_wdata_r <= {DATA_WIDTH{1'b0}};
        end
        ST_WAIT: begin
          resp_rdata_r <= load_ext_s;
        end
        ST_RESP: begin
          if (resp_ready) begin
            resp_err_r   <= 1'b0;
            resp_rdata_r <= {DATA_WIDTH{1'b0}};
          end
        end
        default: begin
          mem_en_r  <= 1'b0;
          mem_wen_r <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready  = req_ready_r;
  assign resp_valid = resp_valid_r;
  assign resp_err   = resp_err_r;
  assign resp_rdata = resp_rdata_r;
  assign mem_en     = mem_en_r;
  assign mem_wen    = mem_wen_r;
  assign mem_wmask  = mem_wmask_r;
  assign mem_addr   = mem_addr_r;
  assign mem_wdata  = mem_wdata_r;

endmodule

// File: tb/tb_lsu_mem_port.sv
// tb_lsu_mem_port: directed plus randomized bench for lsu_mem_port with a
// 1-cycle-latency byte-masked SRAM model and a word-array reference memory.
module tb_lsu_mem_port;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_wen = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_uns = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        mem_en;
  logic        mem_wen;
  logic [7:0]  mem_wmask;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_rdata;
  logic        resp_err;

  int total = 0;
  int bad = 0;

  logic [31:0] sram [0:255];
  logic [31:0] ref_mem [0:255];
  logic        mem_init = 1'b1;

  lsu_mem_port dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_size(req_size), .req_uns(req_uns), .req_addr(req_addr), .req_wdata(req_wdata),
    .mem_en(mem_en), .mem_wen(mem_wen), .mem_wmask(mem_wmask), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_err(resp_err)
  );

  always #5 clk = ~clk;

  // SRAM model: registered read, byte-masked write.
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) sram[i] <= 32'hC0DE0000 | i;
      mem_rdata <= 32'h0;
    end else if (mem_en) begin
      if (mem_wen) begin
        for (int b = 0; b < 4; b++)
          if (mem_wmask[b]) sram[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
      end else begin
        mem_rdata <= sram[mem_addr[9:2]];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Drive one request, check SRAM command, latency and response, then accept it.
  task automatic do_op(input logic wen, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input int hold, output logic [31:0] obs);
    int off, nbytes, lat, k, en_cnt, idx, lane;
    logic err, got;
    logic [31:0] mask_exp, wd_exp, rd_exp, v;
    off    = int'(addr[1:0]);
    idx    = int'(addr[9:2]);
    nbytes = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    err    = (size == 2'd3) || (size == 2'd1 && (off % 2) != 0) || (size == 2'd2 && off != 0);
    lat    = err ? 1 : (wen ? 2 : 3);
    mask_exp = ((32'd1 << nbytes) - 32'd1) << off;
    wd_exp   = wdata << (8 * off);
    rd_exp   = 32'h0;
    if (!err && !wen) begin
      v = (ref_mem[idx] >> (8 * off));
      if (nbytes == 1) begin
        v = v & 32'hFF;
        if (!uns && v >= 32'd128) v = v - 32'd256;
      end else if (nbytes == 2) begin
        v = v & 32'hFFFF;
        if (!uns && v >= 32'd32768) v = v - 32'd65536;
      end
      rd_exp = v;
    end
    @(negedge clk);
    chk("req_ready_idle", req_ready, 1'b1);
    req_valid = 1'b1; req_wen = wen; req_size = size; req_uns = uns;
    req_addr = addr; req_wdata = wdata;
    @(posedge clk);
    k = 0; en_cnt = 0; got = 1'b0;
    while (k < 8 && !got) begin
      @(negedge clk);
      if (k == 0) begin
        req_valid = 1'b0;
        chk("req_ready_busy", req_ready, 1'b0);
      end
      k++;
      if (mem_en) begin
        en_cnt++;
        chk("mem_addr", mem_addr, {addr[31:2], 2'b00});
        chk("mem_wen", mem_wen, wen);
        chk("mem_wmask", {24'h0, mem_wmask}, mask_exp);
        if (wen) chk("mem_wdata", mem_wdata, wd_exp);
      end
      if (resp_valid) got = 1'b1;
    end
    chk("resp_seen", got, 1'b1);
    chk("latency", k, lat);
    chk("mem_en_count", en_cnt, err ? 0 : 1);
    chk("resp_err", resp_err, err);
    chk("resp_rdata", resp_rdata, rd_exp);
    obs = resp_rdata;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("hold_valid", resp_valid, 1'b1);
      chk("hold_rdata", resp_rdata, rd_exp);
      chk("hold_err", resp_err, err);
      chk("hold_ready", req_ready, 1'b0);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    chk("resp_released", resp_valid, 1'b0);
    chk("ready_after", req_ready, 1'b1);
    if (wen && !err) begin
      for (int b = 0; b < nbytes; b++) begin
        lane = off + b;
        ref_mem[idx] = (ref_mem[idx] & ~(32'hFF << (8 * lane))) |
                       (((wdata >> (8 * b)) & 32'hFF) << (8 * lane));
      end
      chk("sram_word", sram[idx], ref_mem[idx]);
    end
  endtask

  initial begin
    logic [31:0] r;
    for (int i = 0; i < 256; i++) ref_mem[i] = 32'hC0DE0000 | i;
    repeat (2) @(posedge clk);
    @(negedge clk);
    mem_init = 1'b0;
    chk("rst_req_ready", req_ready, 1'b1);
    chk("rst_mem_en", mem_en, 1'b0);
    chk("rst_resp_valid", resp_valid, 1'b0);
    chk("rst_resp_rdata", resp_rdata, 32'h0);
    chk("rst_mem_wmask", {24'h0, mem_wmask}, 32'h0);
    rst = 1'b1;

    // 1-2: word and byte stores
    do_op(1'b1, 2'd2, 1'b0, 32'h100, 32'hDEADBEEF, 0, r);
    do_op(1'b1, 2'd0, 1'b0, 32'h103, 32'h000000A5, 0, r);
    chk("sb_result", sram[8'h40], 32'hA5ADBEEF);
    // 3: load extension cases
    do_op(1'b1, 2'd2, 1'b0, 32'h100, 32'h80FF7F01, 0, r);
    do_op(1'b0, 2'd0, 1'b0, 32'h101, 32'h0, 0, r); chk("lb_101", r, 32'h0000007F);
    do_op(1'b0, 2'd0, 1'b0, 32'h103, 32'h0, 0, r); chk("lb_103", r, 32'hFFFFFF80);
    do_op(1'b0, 2'd1, 1'b1, 32'h102, 32'h0, 0, r); chk("lhu_102", r, 32'h000080FF);
    do_op(1'b0, 2'd1, 1'b0, 32'h102, 32'h0, 0, r); chk("lh_102", r, 32'hFFFF80FF);
    do_op(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 0, r); chk("lw_100", r, 32'h80FF7F01);
    // 4: misaligned and illegal size
    do_op(1'b0, 2'd2, 1'b0, 32'h102, 32'h0, 0, r);
    do_op(1'b1, 2'd1, 1'b0, 32'h101, 32'h1234, 0, r);
    do_op(1'b0, 2'd3, 1'b0, 32'h104, 32'h0, 0, r);
    // 5: back-pressure on a load
    do_op(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 5, r);

    // 6: reset during ISSUE of a store
    @(negedge clk);
    req_valid = 1'b1; req_wen = 1'b1; req_size = 2'd2; req_uns = 1'b0;
    req_addr = 32'h104; req_wdata = 32'h12345678;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    chk("issue_mem_en", mem_en, 1'b1);
    rst = 1'b0;
    #1;
    chk("arst_mem_en", mem_en, 1'b0);
    chk("arst_mem_wen", mem_wen, 1'b0);
    chk("arst_mem_wmask", {24'h0, mem_wmask}, 32'h0);
    chk("arst_mem_addr", mem_addr, 32'h0);
    chk("arst_mem_wdata", mem_wdata, 32'h0);
    chk("arst_resp_valid", resp_valid, 1'b0);
    chk("arst_resp_err", resp_err, 1'b0);
    chk("arst_resp_rdata", resp_rdata, 32'h0);
    chk("arst_req_ready", req_ready, 1'b1);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    chk("no_write_after_rst", sram[8'h41], ref_mem[8'h41]);
    chk("ready_after_rst", req_ready, 1'b1);
    do_op(1'b1, 2'd1, 1'b0, 32'h106, 32'h0000BEEF, 0, r);
    do_op(1'b0, 2'd2, 1'b0, 32'h104, 32'h0, 0, r);

    // Randomized traffic in a 64-byte window
    for (int n = 0; n < 40; n++) begin
      do_op(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            32'h100 + 32'($urandom_range(0, 63)), $urandom, $urandom_range(0, 2), r);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
